// File: rtl/ov5640_init_sequencer_pkg.sv
// ov5640_init_sequencer_pkg: sequencer state encoding and OV5640 SCCB constants.
package ov5640_init_sequencer_pkg;
   typedef enum logic [3:0] {
      S_IDLE, S_PWR_WAIT, S_FETCH, S_LATCH, S_WRITE, S_WAIT_ACK, S_SETTLE, S_DONE, S_ERROR
   } state_t;
   localparam logic [7:0]  OV5640_DEV_ID = 8'h78;
   localparam logic [15:0] SWRST_REG     = 16'h3008;
   function automatic logic is_swrst(input logic [15:0] addr, input logic [7:0] data);
      return addr == SWRST_REG && data[7];
   endfunction
endpackage

// File: rtl/ov5640_init_sequencer_if.sv
// ov5640_init_sequencer_if: ROM read port and SCCB write-request bus of the init sequencer.
interface ov5640_init_sequencer_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 24
);
   logic [ADDR_WIDTH-1:0] rom_addr;
   logic [DATA_WIDTH-1:0] rom_q;
   logic                  wr_req;
   logic [15:0]           wr_reg_addr;
   logic [7:0]            wr_reg_data;
   logic                  wr_done;
   logic                  wr_nack;
   modport master(output rom_addr, wr_req, wr_reg_addr, wr_reg_data, input rom_q, wr_done, wr_nack);
   modport slave(input rom_addr, wr_req, wr_reg_addr, wr_reg_data, output rom_q, wr_done, wr_nack);
endinterface

// File: rtl/ov5640_init_sequencer_delay.sv
// ov5640_init_sequencer_delay: settle-delay counter, cleared on state entry, expires at limit-1.
module ov5640_init_sequencer_delay #(
   parameter int DLY_W = 21
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [DLY_W-1:0] limit_i,
   output logic             expired_o
);
   logic [DLY_W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + DLY_W'(1) : cnt_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   // a zero limit still costs the one cycle spent in the waiting state
   assign expired_o = (limit_i == '0) || (cnt_q == limit_i - DLY_W'(1));
endmodule

// File: rtl/ov5640_init_sequencer.sv
// ov5640_init_sequencer: walks the OV5640 init ROM, issues one SCCB write per entry with
// power-up/soft-reset settle delays and NACK retries, then reports done or error.
module ov5640_init_sequencer
   import ov5640_init_sequencer_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 24,
   parameter int REG_NUM    = 252,
   parameter int PWRUP_DLY  = 1000000,
   parameter int SWRST_DLY  = 250000,
   parameter int MAX_RETRY  = 3,
   parameter int DLY_W      = 21
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   ov5640_init_sequencer_if.master bus,
   output logic                  init_busy_o,
   output logic                  init_done_o,
   output logic                  init_error_o,
   output logic [ADDR_WIDTH-1:0] err_index_o
);
   localparam int RW = $clog2(MAX_RETRY + 2);
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d, eidx_q, eidx_d;
   logic [RW-1:0]         retry_q, retry_d;
   logic [15:0]           raddr_q, raddr_d;
   logic [7:0]            rdata_q, rdata_d;
   logic                  req_q, req_d, advance, last, dly_exp;
   assign last = idx_q == ADDR_WIDTH'(REG_NUM - 1);
   ov5640_init_sequencer_delay #(.DLY_W(DLY_W)) u_dly (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (state_d != state_q),
      .en_i      (state_q == S_PWR_WAIT || state_q == S_SETTLE),
      .limit_i   (state_q == S_SETTLE ? DLY_W'(SWRST_DLY) : DLY_W'(PWRUP_DLY)),
      .expired_o (dly_exp)
   );
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      eidx_d  = eidx_q;
      retry_d = retry_q;
      raddr_d = raddr_q;
      rdata_d = rdata_q;
      advance = 1'b0;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: if (start_i) begin
            state_d = S_PWR_WAIT;
            idx_d   = '0;
            eidx_d  = '0;
            retry_d = '0;
         end
         S_PWR_WAIT: if (dly_exp) state_d = S_FETCH;
         S_FETCH:    state_d = S_LATCH;
         S_LATCH: begin
            raddr_d = bus.rom_q[DATA_WIDTH-1 -: 16];
            rdata_d = bus.rom_q[7:0];
            state_d = S_WRITE;
         end
         S_WRITE:    state_d = S_WAIT_ACK;
         S_WAIT_ACK: if (bus.wr_done) begin
            if (!bus.wr_nack) begin
               if (is_swrst(raddr_q, rdata_q)) state_d = S_SETTLE;
               else advance = 1'b1;
            end else if (retry_q < RW'(MAX_RETRY)) begin
               retry_d = retry_q + RW'(1);
               state_d = S_WRITE;
            end else begin
               eidx_d  = idx_q;
               state_d = S_ERROR;
            end
         end
         S_SETTLE:   advance = dly_exp;
         default:    ;
      endcase
      // the last entry holds the index so it never wraps
      if (advance) begin
         retry_d = '0;
         idx_d   = last ? idx_q : idx_q + ADDR_WIDTH'(1);
         state_d = last ? S_DONE : S_FETCH;
      end
   end
   // a retry passes through WRITE with wr_req low so the SCCB master sees a fresh request
   assign req_d = state_d == S_WAIT_ACK || (state_d == S_WRITE && state_q == S_LATCH);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         eidx_q  <= '0;
         retry_q <= '0;
         raddr_q <= '0;
         rdata_q <= '0;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         eidx_q  <= eidx_d;
         retry_q <= retry_d;
         raddr_q <= raddr_d;
         rdata_q <= rdata_d;
         req_q   <= req_d;
      end
   assign bus.rom_addr    = idx_q;
   assign bus.wr_req      = req_q;
   assign bus.wr_reg_addr = raddr_q;
   assign bus.wr_reg_data = rdata_q;
   assign init_busy_o     = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
   assign init_done_o     = state_q == S_DONE;
   assign init_error_o    = state_q == S_ERROR;
   assign err_index_o     = eidx_q;
endmodule
